// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer in front of the byte-serial memory controller.
// Grants fetch or load/store, holds the transaction stable, and returns the result with a one-cycle ack.
module mem_port_arbiter #(
  parameter bit          LS_PRIORITY = 1'b1,
  parameter int unsigned TIMEOUT     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_address,
  output logic        if_ack,
  output logic [31:0] if_read_data,
  output logic        if_error,
  input  logic        ls_req,
  input  logic [31:0] ls_address,
  input  logic [2:0]  ls_mode,
  input  logic        ls_write_enable,
  input  logic [31:0] ls_write_data,
  output logic        ls_ack,
  output logic [31:0] ls_read_data,
  output logic        ls_error,
  output logic        mem_start,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_mode,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic        mem_done,
  input  logic [31:0] mem_read_data,
  input  logic        mem_active
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam logic [2:0] FETCH_MODE   = 3'b010;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        grant_ls_q, grant_ls_d;
  logic        last_ls_q, last_ls_d;
  logic [7:0]  timeout_cnt_q, timeout_cnt_d;
  logic        mem_start_q, mem_start_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [2:0]  mem_mode_q, mem_mode_d;
  logic        mem_write_enable_q, mem_write_enable_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        if_ack_q, if_ack_d;
  logic        ls_ack_q, ls_ack_d;
  logic        if_error_q, if_error_d;
  logic        ls_error_q, ls_error_d;
  logic [31:0] if_read_data_q, if_read_data_d;
  logic [31:0] ls_read_data_q, ls_read_data_d;

  logic req_any;
  logic pick_ls;
  logic timeout_hit;
  logic mem_active_unused;

  // Controller busy is informational only; sequencing relies on the FSM alone.
  assign mem_active_unused = mem_active;

  assign req_any     = if_req | ls_req;
  // On a tie, round-robin favours load/store unless it was the last port granted.
  assign pick_ls     = ls_req & (~if_req | LS_PRIORITY | ~last_ls_q);
  // The WAIT cycle holding count TIMEOUT-1 is the TIMEOUT-th one, so it aborts.
  assign timeout_hit = (timeout_cnt_q == TIMEOUT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mem_done || timeout_hit) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_ls_d         = grant_ls_q;
    last_ls_d          = last_ls_q;
    timeout_cnt_d      = timeout_cnt_q;
    mem_start_d        = 1'b0;
    mem_address_d      = mem_address_q;
    mem_mode_d         = mem_mode_q;
    mem_write_enable_d = mem_write_enable_q;
    mem_write_data_d   = mem_write_data_q;
    if_ack_d           = 1'b0;
    ls_ack_d           = 1'b0;
    if_error_d         = 1'b0;
    ls_error_d         = 1'b0;
    if_read_data_d     = if_read_data_q;
    ls_read_data_d     = ls_read_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          grant_ls_d  = pick_ls;
          last_ls_d   = pick_ls;
          mem_start_d = 1'b1;
          if (pick_ls) begin
            mem_address_d      = ls_address;
            mem_mode_d         = ls_mode;
            mem_write_enable_d = ls_write_enable;
            mem_write_data_d   = ls_write_data;
          end else begin
            mem_address_d      = if_address;
            mem_mode_d         = FETCH_MODE;
            mem_write_enable_d = 1'b0;
            mem_write_data_d   = 32'd0;
          end
        end
      end
      ST_ISSUE: timeout_cnt_d = 8'd0;
      ST_WAIT: begin
        // A completion on the final cycle still counts as success.
        if (mem_done) begin
          if (grant_ls_q) begin
            ls_read_data_d = mem_read_data;
            ls_ack_d       = 1'b1;
          end else begin
            if_read_data_d = mem_read_data;
            if_ack_d       = 1'b1;
          end
        end else if (timeout_hit) begin
          if (grant_ls_q) begin
            ls_read_data_d = 32'd0;
            ls_ack_d       = 1'b1;
            ls_error_d     = 1'b1;
          end else begin
            if_read_data_d = 32'd0;
            if_ack_d       = 1'b1;
            if_error_d     = 1'b1;
          end
        end else begin
          timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: every register here is a plain flop, so all of them take the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_ls_q         <= 1'b0;
      last_ls_q          <= 1'b0;
      timeout_cnt_q      <= 8'd0;
      mem_start_q        <= 1'b0;
      mem_address_q      <= 32'd0;
      mem_mode_q         <= 3'd0;
      mem_write_enable_q <= 1'b0;
      mem_write_data_q   <= 32'd0;
      if_ack_q           <= 1'b0;
      ls_ack_q           <= 1'b0;
      if_error_q         <= 1'b0;
      ls_error_q         <= 1'b0;
      if_read_data_q     <= 32'd0;
      ls_read_data_q     <= 32'd0;
    end else begin
      grant_ls_q         <= grant_ls_d;
      last_ls_q          <= last_ls_d;
      timeout_cnt_q      <= timeout_cnt_d;
      mem_start_q        <= mem_start_d;
      mem_address_q      <= mem_address_d;
      mem_mode_q         <= mem_mode_d;
      mem_write_enable_q <= mem_write_enable_d;
      mem_write_data_q   <= mem_write_data_d;
      if_ack_q           <= if_ack_d;
      ls_ack_q           <= ls_ack_d;
      if_error_q         <= if_error_d;
      ls_error_q         <= ls_error_d;
      if_read_data_q     <= if_read_data_d;
      ls_read_data_q     <= ls_read_data_d;
    end
  end

  assign mem_start        = mem_start_q;
  assign mem_address      = mem_address_q;
  assign mem_mode         = mem_mode_q;
  assign mem_write_enable = mem_write_enable_q;
  assign mem_write_data   = mem_write_data_q;
  assign if_ack           = if_ack_q;
  assign ls_ack           = ls_ack_q;
  assign if_error         = if_error_q;
  assign ls_error         = ls_error_q;
  assign if_read_data     = if_read_data_q;
  assign ls_read_data     = ls_read_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance 0 uses load/store priority with TIMEOUT=4,
// instance 1 uses round-robin; a behavioural controller model answers each mem_start.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  logic        if_req[2];
  logic [31:0] if_address[2];
  logic        if_ack[2];
  logic [31:0] if_read_data[2];
  logic        if_error[2];
  logic        ls_req[2];
  logic [31:0] ls_address[2];
  logic [2:0]  ls_mode[2];
  logic        ls_write_enable[2];
  logic [31:0] ls_write_data[2];
  logic        ls_ack[2];
  logic [31:0] ls_read_data[2];
  logic        ls_error[2];
  logic        mem_start[2];
  logic [31:0] mem_address[2];
  logic [2:0]  mem_mode[2];
  logic        mem_write_enable[2];
  logic [31:0] mem_write_data[2];
  logic        mem_done[2];
  logic [31:0] mem_read_data[2];
  logic        mem_active[2];

  int          ctrl_lat[2];
  bit          ctrl_hang[2];
  logic [31:0] ctrl_resp[2];
  int          m_cnt[2]      = '{0, 0};
  bit          m_busy[2]     = '{1'b0, 1'b0};
  int          start_cnt[2]  = '{0, 0};
  int          done_cnt[2]   = '{0, 0};
  int          if_ack_cnt[2] = '{0, 0};
  int          ls_ack_cnt[2] = '{0, 0};

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LS_PRIORITY(1'b1), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_address(if_address[0]), .if_ack(if_ack[0]),
    .if_read_data(if_read_data[0]), .if_error(if_error[0]),
    .ls_req(ls_req[0]), .ls_address(ls_address[0]), .ls_mode(ls_mode[0]),
    .ls_write_enable(ls_write_enable[0]), .ls_write_data(ls_write_data[0]),
    .ls_ack(ls_ack[0]), .ls_read_data(ls_read_data[0]), .ls_error(ls_error[0]),
    .mem_start(mem_start[0]), .mem_address(mem_address[0]), .mem_mode(mem_mode[0]),
    .mem_write_enable(mem_write_enable[0]), .mem_write_data(mem_write_data[0]),
    .mem_done(mem_done[0]), .mem_read_data(mem_read_data[0]), .mem_active(mem_active[0])
  );

  mem_port_arbiter #(.LS_PRIORITY(1'b0), .TIMEOUT(32)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_address(if_address[1]), .if_ack(if_ack[1]),
    .if_read_data(if_read_data[1]), .if_error(if_error[1]),
    .ls_req(ls_req[1]), .ls_address(ls_address[1]), .ls_mode(ls_mode[1]),
    .ls_write_enable(ls_write_enable[1]), .ls_write_data(ls_write_data[1]),
    .ls_ack(ls_ack[1]), .ls_read_data(ls_read_data[1]), .ls_error(ls_error[1]),
    .mem_start(mem_start[1]), .mem_address(mem_address[1]), .mem_mode(mem_mode[1]),
    .mem_write_enable(mem_write_enable[1]), .mem_write_data(mem_write_data[1]),
    .mem_done(mem_done[1]), .mem_read_data(mem_read_data[1]), .mem_active(mem_active[1])
  );

  // Controller model: done arrives ctrl_lat negedges after start is seen, never if hung.
  // Read data is wrong except in the done cycle, so a mistimed capture shows up.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      mem_done[g]      = 1'b0;
      mem_read_data[g] = ~ctrl_resp[g];
      if (m_busy[g]) begin
        if (m_cnt[g] <= 1) begin
          mem_done[g]      = 1'b1;
          mem_read_data[g] = ctrl_resp[g];
          m_busy[g]        = 1'b0;
          done_cnt[g]++;
        end else begin
          m_cnt[g]--;
        end
      end
      if (mem_start[g] === 1'b1 && !ctrl_hang[g]) begin
        m_busy[g] = 1'b1;
        m_cnt[g]  = ctrl_lat[g];
      end
      mem_active[g] = m_busy[g];
      if (mem_start[g] === 1'b1) start_cnt[g]++;
      if (if_ack[g] === 1'b1)    if_ack_cnt[g]++;
      if (ls_ack[g] === 1'b1)    ls_ack_cnt[g]++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic wait_start(input int d, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = (mem_start[d] === 1'b1);
    end
    check({tag, "_start_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic wait_ack(input int d, input string tag, output int n, output bit is_ls);
    bit seen = 1'b0;
    n     = 0;
    is_ls = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (if_ack[d] === 1'b1 || ls_ack[d] === 1'b1) begin
        seen  = 1'b1;
        is_ls = (ls_ack[d] === 1'b1);
      end
    end
    check({tag, "_ack_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   is_ls;
    int   snap_start, snap_if, snap_ls, snap_done;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0;          if_address[d] = 32'd0;
      ls_req[d] = 1'b0;          ls_address[d] = 32'd0;
      ls_mode[d] = 3'd0;         ls_write_enable[d] = 1'b0;
      ls_write_data[d] = 32'd0;  ctrl_lat[d] = 1;
      ctrl_hang[d] = 1'b0;       ctrl_resp[d] = 32'd0;
    end
    repeat (3) step();

    check("reset_ctrl_bits", 64'({mem_start[0], if_ack[0], ls_ack[0], if_error[0], ls_error[0], mem_write_enable[0]}), 64'd0);
    check("reset_mem_fields", {mem_address[0], mem_write_data[0]}, 64'd0);
    check("reset_read_data", {if_read_data[0], ls_read_data[0]}, 64'd0);
    reset = 1'b0;
    step();

    // Fetch alone.
    ctrl_lat[0] = 3; ctrl_resp[0] = 32'hDEADBEEF;
    if_address[0] = 32'h100; if_req[0] = 1'b1;
    wait_start(0, "fetch");
    check("fetch_mode", 64'(mem_mode[0]), 64'h2);
    check("fetch_addr", 64'(mem_address[0]), 64'h100);
    check("fetch_we", 64'(mem_write_enable[0]), 64'd0);
    if_req[0] = 1'b0;
    step();
    check("fetch_start_one_cycle", 64'(mem_start[0]), 64'd0);
    wait_ack(0, "fetch", n, is_ls);
    check("fetch_latency", 64'(n), 64'd3);
    check("fetch_port", 64'(is_ls), 64'd0);
    check("fetch_data", 64'(if_read_data[0]), 64'hDEADBEEF);
    check("fetch_error", 64'(if_error[0]), 64'd0);
    step();
    check("fetch_ack_one_cycle", 64'(if_ack[0]), 64'd0);
    check("fetch_start_count", 64'(start_cnt[0]), 64'd1);

    // Store byte: fields stay latched until the controller finishes.
    ctrl_lat[0] = 2; ctrl_resp[0] = 32'h55AA55AA;
    ls_address[0] = 32'h20; ls_mode[0] = 3'b000; ls_write_enable[0] = 1'b1;
    ls_write_data[0] = 32'h000000A5; ls_req[0] = 1'b1;
    snap_if = if_ack_cnt[0];
    wait_start(0, "store");
    ls_req[0] = 1'b0;
    check("store_fields_at_start", {mem_address[0], 28'd0, mem_mode[0], mem_write_enable[0]}, {32'h20, 28'd0, 3'b000, 1'b1});
    step();
    step();
    check("store_done_cycle", 64'(mem_done[0]), 64'd1);
    check("store_fields_at_done", {mem_address[0], 28'd0, mem_mode[0], mem_write_enable[0]}, {32'h20, 28'd0, 3'b000, 1'b1});
    check("store_wdata_at_done", 64'(mem_write_data[0]), 64'hA5);
    wait_ack(0, "store", n, is_ls);
    check("store_latency", 64'(n), 64'd1);
    check("store_port", 64'(is_ls), 64'd1);
    check("store_error", 64'(ls_error[0]), 64'd0);
    check("store_no_if_ack", 64'(if_ack_cnt[0] - snap_if), 64'd0);
    check("store_if_data_held", 64'(if_read_data[0]), 64'hDEADBEEF);

    // Tie with load/store priority: a re-raised ls_req keeps winning.
    ctrl_lat[0] = 1; ctrl_resp[0] = 32'h0000_1111;
    ls_address[0] = 32'h40; ls_mode[0] = 3'b010; ls_write_enable[0] = 1'b0;
    if_address[0] = 32'h100;
    ls_req[0] = 1'b1; if_req[0] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_start(0, "prio_ls");
      check("prio_ls_addr", 64'(mem_address[0]), 64'h40);
      wait_ack(0, "prio_ls", n, is_ls);
      check("prio_ls_port", 64'(is_ls), 64'd1);
      if (t == 2) ls_req[0] = 1'b0;
    end
    wait_start(0, "prio_if");
    check("prio_if_addr", 64'(mem_address[0]), 64'h100);
    if_req[0] = 1'b0;
    wait_ack(0, "prio_if", n, is_ls);
    check("prio_if_port", 64'(is_ls), 64'd0);
    check("prio_if_data", 64'(if_read_data[0]), 64'h1111);

    // Watchdog abort with TIMEOUT=4, then a normal load.
    ctrl_hang[0] = 1'b1;
    ls_address[0] = 32'h80; ls_req[0] = 1'b1;
    wait_start(0, "timeout");
    ls_req[0] = 1'b0;
    wait_ack(0, "timeout", n, is_ls);
    check("timeout_latency", 64'(n), 64'd5);
    check("timeout_port", 64'(is_ls), 64'd1);
    check("timeout_error", 64'(ls_error[0]), 64'd1);
    check("timeout_data", 64'(ls_read_data[0]), 64'd0);
    step();
    check("timeout_ack_drop", 64'({ls_ack[0], ls_error[0]}), 64'd0);
    ctrl_hang[0] = 1'b0;
    ctrl_lat[0] = 1; ctrl_resp[0] = 32'h12345678;
    ls_address[0] = 32'h84; ls_req[0] = 1'b1;
    wait_start(0, "recover");
    ls_req[0] = 1'b0;
    wait_ack(0, "recover", n, is_ls);
    check("recover_latency", 64'(n), 64'd2);
    check("recover_data", 64'(ls_read_data[0]), 64'h12345678);
    check("recover_error", 64'(ls_error[0]), 64'd0);

    // Reset mid-WAIT; the late completion must be ignored.
    ctrl_lat[0] = 6; ctrl_resp[0] = 32'hCAFEF00D;
    if_address[0] = 32'h104; if_req[0] = 1'b1;
    wait_start(0, "rst_wait");
    if_req[0] = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("rst_ctrl_bits", 64'({mem_start[0], if_ack[0], ls_ack[0], if_error[0], ls_error[0], mem_write_enable[0]}), 64'd0);
    check("rst_mem_addr", 64'(mem_address[0]), 64'd0);
    check("rst_read_data", {if_read_data[0], ls_read_data[0]}, 64'd0);
    snap_start = start_cnt[0]; snap_if = if_ack_cnt[0];
    snap_ls = ls_ack_cnt[0];   snap_done = done_cnt[0];
    step();
    reset = 1'b0;
    repeat (8) step();
    check("rst_stray_done_seen", 64'(done_cnt[0] - snap_done), 64'd1);
    check("rst_no_activity", 64'((start_cnt[0] - snap_start) + (if_ack_cnt[0] - snap_if) + (ls_ack_cnt[0] - snap_ls)), 64'd0);
    check("rst_data_still_zero", 64'(if_read_data[0]), 64'd0);
    ctrl_lat[0] = 2; ctrl_resp[0] = 32'h0BADCAFE;
    if_address[0] = 32'h108; if_req[0] = 1'b1;
    wait_start(0, "post_rst");
    check("post_rst_addr", 64'(mem_address[0]), 64'h108);
    if_req[0] = 1'b0;
    wait_ack(0, "post_rst", n, is_ls);
    check("post_rst_latency", 64'(n), 64'd3);
    check("post_rst_data", 64'(if_read_data[0]), 64'h0BADCAFE);

    // Round-robin instance: both held for four grants gives L,F,L,F.
    ctrl_lat[1] = 1; ctrl_resp[1] = 32'h77;
    if_address[1] = 32'h300; ls_address[1] = 32'h200;
    ls_mode[1] = 3'b010; ls_write_enable[1] = 1'b0;
    if_req[1] = 1'b1; ls_req[1] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_start(1, "rr");
      check("rr_addr", 64'(mem_address[1]), (t % 2 == 0) ? 64'h200 : 64'h300);
      if (t == 3) begin
        if_req[1] = 1'b0;
        ls_req[1] = 1'b0;
      end
      wait_ack(1, "rr", n, is_ls);
      check("rr_port", 64'(is_ls), (t % 2 == 0) ? 64'd1 : 64'd0);
    end
    check("rr_start_count", 64'(start_cnt[1]), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
